// File: rtl/wired_bus_pkg.sv
// Shared types and helpers for the wired bus resolver.
// Holds the resolution mode enum, default sizes and the idle-bus value helper.
package wired_bus_pkg;

    typedef enum logic [1:0] {
        RES_WOR  = 2'd0,
        RES_WAND = 2'd1,
        RES_TRI  = 2'd2
    } res_mode_e;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_NDRV   = 3;
    localparam int DEF_FILTER = 2;
    localparam int DEF_CNT_W  = 8;

    // Value the bus settles to with no driver: all-ones for wired-AND,
    // zero otherwise. Only the low `width` bits are meaningful.
    function automatic logic [63:0] undriven_value(
        input res_mode_e mode,
        input int        width
    );
        logic [63:0] v;
        v = '0;
        if (mode == RES_WAND) begin
            for (int i = 0; i < 64; i++) begin
                if (i < width) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/wired_bus_conflict_filter.sv
// Contention filter and error bookkeeping for the wired bus resolver.
// Ports: clk, rst (sync, active-high), raw_conflict, drv_en, clr_err in;
//        conflict, err_sticky, err_count, err_mask out (all registered).
module wired_bus_conflict_filter
    import wired_bus_pkg::*;
#(
    parameter int FILTER = DEF_FILTER,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int NDRV   = DEF_NDRV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             raw_conflict,
    input  logic [NDRV-1:0]  drv_en,
    input  logic             clr_err,
    output logic             conflict,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [NDRV-1:0]  err_mask
);

    localparam int RUN_W = $clog2(FILTER + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILTER);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [RUN_W-1:0] r_run;
    logic             r_conflict;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;
    logic [NDRV-1:0]  r_mask;

    logic [RUN_W-1:0] w_run_next;
    logic             w_conflict_next;
    logic             w_episode;
    logic [CNT_W-1:0] w_count_inc;

    always_comb begin
        w_run_next = '0;
        if (raw_conflict) begin
            w_run_next = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
        end
    end

    assign w_conflict_next = (w_run_next == RUN_MAX);
    assign w_episode       = w_conflict_next && !r_conflict;
    assign w_count_inc     = (r_count == CNT_MAX) ? r_count : r_count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run      <= '0;
            r_conflict <= 1'b0;
            r_sticky   <= 1'b0;
            r_count    <= '0;
            r_mask     <= '0;
        end else begin
            r_run      <= w_run_next;
            r_conflict <= w_conflict_next;
            if (w_episode) begin
                // A clear on the same edge only zeroes the old tally.
                r_count  <= clr_err ? CNT_W'(1) : w_count_inc;
                r_sticky <= 1'b1;
                r_mask   <= drv_en;
            end else if (clr_err) begin
                r_count  <= '0;
                r_sticky <= 1'b0;
            end
        end
    end

    assign conflict   = r_conflict;
    assign err_sticky = r_sticky;
    assign err_count  = r_count;
    assign err_mask   = r_mask;

endmodule

// File: rtl/wired_bus_resolver.sv
// Registered N-driver bus resolver: wired-OR, wired-AND or tri-state+keeper.
// Ports: clk, rst, drv_en, drv_data, clr_err in; bus_q, bus_valid, conflict,
//        err_sticky, err_count, err_mask out (all registered).
module wired_bus_resolver
    import wired_bus_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NDRV   = DEF_NDRV,
    parameter int MODE   = 0,
    parameter int FILTER = DEF_FILTER,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NDRV-1:0]       drv_en,
    input  logic [NDRV*WIDTH-1:0] drv_data,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      bus_q,
    output logic                  bus_valid,
    output logic                  conflict,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      err_count,
    output logic [NDRV-1:0]       err_mask
);

    localparam res_mode_e P_MODE = res_mode_e'(MODE);
    localparam logic [63:0] IDLE_VAL = undriven_value(P_MODE, WIDTH);
    localparam logic [WIDTH-1:0] RST_VAL = IDLE_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_bus;
    logic             r_valid;

    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_first;
    logic             w_seen;
    logic             w_diff;
    logic [WIDTH-1:0] w_bus_next;
    logic             w_raw;

    // Every enabled driver is compared with the first one found; any
    // mismatch means the drivers disagree.
    always_comb begin
        w_or    = '0;
        w_and   = '1;
        w_first = '0;
        w_seen  = 1'b0;
        w_diff  = 1'b0;
        for (int i = 0; i < NDRV; i++) begin
            if (drv_en[i]) begin
                w_or  = w_or | drv_data[i*WIDTH +: WIDTH];
                w_and = w_and & drv_data[i*WIDTH +: WIDTH];
                if (!w_seen) begin
                    w_first = drv_data[i*WIDTH +: WIDTH];
                    w_seen  = 1'b1;
                end else if (drv_data[i*WIDTH +: WIDTH] != w_first) begin
                    w_diff = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_bus_next = r_bus;
        w_raw      = 1'b0;
        case (P_MODE)
            RES_WOR:  w_bus_next = w_or;
            RES_WAND: w_bus_next = w_and;
            default: begin
                // Keeper: hold on no driver or on disagreement.
                if (w_seen && !w_diff) w_bus_next = w_first;
                w_raw = w_diff;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus   <= RST_VAL;
            r_valid <= 1'b0;
        end else begin
            r_bus   <= w_bus_next;
            r_valid <= |drv_en;
        end
    end

    assign bus_q     = r_bus;
    assign bus_valid = r_valid;

    wired_bus_conflict_filter #(
        .FILTER (FILTER),
        .CNT_W  (CNT_W),
        .NDRV   (NDRV)
    ) u_filter (
        .clk          (clk),
        .rst          (rst),
        .raw_conflict (w_raw),
        .drv_en       (drv_en),
        .clr_err      (clr_err),
        .conflict     (conflict),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .err_mask     (err_mask)
    );

endmodule

// File: tb/tb_wired_bus_resolver.sv
// Directed bench for wired_bus_resolver.
// Four instances share one stimulus bundle: OR, AND, tri (F=2), tri (F=1, CNT_W=2).
module tb_wired_bus_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  drv_en;
    logic [11:0] drv_data;
    logic        clr_err;

    logic [3:0] or_q, and_q, tri_q, sat_q;
    logic       or_v, and_v, tri_v, sat_v;
    logic       or_c, and_c, tri_c, sat_c;
    logic       or_s, and_s, tri_s, sat_s;
    logic [7:0] or_n, and_n, tri_n;
    logic [1:0] sat_n;
    logic [2:0] or_m, and_m, tri_m, sat_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wired_bus_resolver #(.WIDTH(4), .NDRV(3), .MODE(0), .FILTER(2), .CNT_W(8)) u_or (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .clr_err(clr_err),
        .bus_q(or_q), .bus_valid(or_v), .conflict(or_c), .err_sticky(or_s),
        .err_count(or_n), .err_mask(or_m));

    wired_bus_resolver #(.WIDTH(4), .NDRV(3), .MODE(1), .FILTER(2), .CNT_W(8)) u_and (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .clr_err(clr_err),
        .bus_q(and_q), .bus_valid(and_v), .conflict(and_c), .err_sticky(and_s),
        .err_count(and_n), .err_mask(and_m));

    wired_bus_resolver #(.WIDTH(4), .NDRV(3), .MODE(2), .FILTER(2), .CNT_W(8)) u_tri (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .clr_err(clr_err),
        .bus_q(tri_q), .bus_valid(tri_v), .conflict(tri_c), .err_sticky(tri_s),
        .err_count(tri_n), .err_mask(tri_m));

    wired_bus_resolver #(.WIDTH(4), .NDRV(3), .MODE(2), .FILTER(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .drv_en(drv_en), .drv_data(drv_data), .clr_err(clr_err),
        .bus_q(sat_q), .bus_valid(sat_v), .conflict(sat_c), .err_sticky(sat_s),
        .err_count(sat_n), .err_mask(sat_m));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; drv_en = '0; drv_data = '0; clr_err = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (or_q !== 4'h0) begin n_bad++; $display("FAIL rst_or_q: got %h want 0", or_q); end
        n_cmp++; if (and_q !== 4'hF) begin n_bad++; $display("FAIL rst_and_q: got %h want f", and_q); end
        n_cmp++; if (tri_q !== 4'h0) begin n_bad++; $display("FAIL rst_tri_q: got %h want 0", tri_q); end
        n_cmp++; if ({or_v, and_v, tri_v, sat_v} !== 4'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0000", {or_v, and_v, tri_v, sat_v}); end
        n_cmp++; if ({tri_c, tri_s, tri_n, tri_m} !== 13'h0) begin n_bad++; $display("FAIL rst_tri_err: got %h want 0", {tri_c, tri_s, tri_n, tri_m}); end
        n_cmp++; if ({sat_c, sat_s, sat_n, sat_m} !== 7'h0) begin n_bad++; $display("FAIL rst_sat_err: got %h want 0", {sat_c, sat_s, sat_n, sat_m}); end
    endtask

    task automatic test_wor();
        do_reset();
        drv_en = 3'b011; drv_data = {4'h0, 4'b0001, 4'b1100};
        step();
        n_cmp++; if (or_q !== 4'b1101) begin n_bad++; $display("FAIL wor_q: got %b want 1101", or_q); end
        n_cmp++; if (or_v !== 1'b1) begin n_bad++; $display("FAIL wor_valid: got %b want 1", or_v); end
        drv_en = 3'b000;
        step();
        n_cmp++; if (or_q !== 4'b0000) begin n_bad++; $display("FAIL wor_idle_q: got %b want 0000", or_q); end
        n_cmp++; if (or_v !== 1'b0) begin n_bad++; $display("FAIL wor_idle_valid: got %b want 0", or_v); end
        n_cmp++; if ({or_c, or_s, or_n} !== 10'h0) begin n_bad++; $display("FAIL wor_no_err: got %h want 0", {or_c, or_s, or_n}); end
    endtask

    task automatic test_wand();
        do_reset();
        drv_en = 3'b101; drv_data = {4'b0111, 4'b0000, 4'b1110};
        step();
        n_cmp++; if (and_q !== 4'b0110) begin n_bad++; $display("FAIL wand_q: got %b want 0110", and_q); end
        drv_en = 3'b000;
        step();
        n_cmp++; if (and_q !== 4'b1111) begin n_bad++; $display("FAIL wand_idle_q: got %b want 1111", and_q); end
        n_cmp++; if ({and_c, and_s, and_n} !== 10'h0) begin n_bad++; $display("FAIL wand_no_err: got %h want 0", {and_c, and_s, and_n}); end
    endtask

    task automatic test_tri_keeper();
        do_reset();
        drv_en = 3'b010; drv_data = {4'h0, 4'hA, 4'h0};
        step();
        n_cmp++; if (tri_q !== 4'hA) begin n_bad++; $display("FAIL tri_one_q: got %h want a", tri_q); end
        drv_en = 3'b000;
        step();
        n_cmp++; if (tri_q !== 4'hA) begin n_bad++; $display("FAIL tri_keep_q: got %h want a", tri_q); end
        n_cmp++; if (tri_v !== 1'b0) begin n_bad++; $display("FAIL tri_keep_valid: got %b want 0", tri_v); end
        drv_en = 3'b110; drv_data = {4'h5, 4'h5, 4'h0};
        step();
        step();
        n_cmp++; if (tri_q !== 4'h5) begin n_bad++; $display("FAIL tri_agree_q: got %h want 5", tri_q); end
        n_cmp++; if ({tri_c, tri_n} !== 9'h0) begin n_bad++; $display("FAIL tri_agree_err: got %h want 0", {tri_c, tri_n}); end
    endtask

    task automatic test_contention();
        do_reset();
        drv_en = 3'b010; drv_data = {4'h0, 4'h9, 4'h0};
        step();
        drv_en = 3'b011; drv_data = {4'h0, 4'h4, 4'h3};
        step();
        n_cmp++; if (tri_c !== 1'b0) begin n_bad++; $display("FAIL cont_short_c: got %b want 0", tri_c); end
        n_cmp++; if (tri_q !== 4'h9) begin n_bad++; $display("FAIL cont_short_q: got %h want 9", tri_q); end
        drv_en = 3'b000;
        step();
        n_cmp++; if (tri_n !== 8'd0) begin n_bad++; $display("FAIL cont_short_n: got %0d want 0", tri_n); end
        drv_en = 3'b011;
        step();
        n_cmp++; if (tri_c !== 1'b0) begin n_bad++; $display("FAIL cont_e1_c: got %b want 0", tri_c); end
        step();
        n_cmp++; if (tri_c !== 1'b1) begin n_bad++; $display("FAIL cont_e2_c: got %b want 1", tri_c); end
        n_cmp++; if (tri_n !== 8'd1) begin n_bad++; $display("FAIL cont_e2_n: got %0d want 1", tri_n); end
        n_cmp++; if (tri_s !== 1'b1) begin n_bad++; $display("FAIL cont_e2_s: got %b want 1", tri_s); end
        n_cmp++; if (tri_m !== 3'b011) begin n_bad++; $display("FAIL cont_e2_m: got %b want 011", tri_m); end
        step();
        n_cmp++; if ({tri_c, tri_n} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL cont_e3: got %h want 101", {tri_c, tri_n}); end
        n_cmp++; if (tri_q !== 4'h9) begin n_bad++; $display("FAIL cont_hold_q: got %h want 9", tri_q); end
        drv_en = 3'b000;
        step();
        n_cmp++; if ({tri_c, tri_n} !== {1'b0, 8'd1}) begin n_bad++; $display("FAIL cont_end: got %h want 001", {tri_c, tri_n}); end
    endtask

    task automatic test_saturate_clear();
        logic [1:0] want;
        do_reset();
        drv_data = {4'h0, 4'h4, 4'h3};
        for (int k = 1; k <= 4; k++) begin
            drv_en = 3'b011;
            step();
            want = (k > 3) ? 2'd3 : 2'(k);
            n_cmp++; if ({sat_c, sat_n} !== {1'b1, want}) begin n_bad++; $display("FAIL sat_ep%0d: got %b want %b", k, {sat_c, sat_n}, {1'b1, want}); end
            drv_en = 3'b000;
            step();
        end
        n_cmp++; if (sat_s !== 1'b1) begin n_bad++; $display("FAIL sat_sticky: got %b want 1", sat_s); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_cmp++; if ({sat_s, sat_n} !== 3'b000) begin n_bad++; $display("FAIL clr: got %b want 000", {sat_s, sat_n}); end
        n_cmp++; if (sat_m !== 3'b011) begin n_bad++; $display("FAIL clr_mask: got %b want 011", sat_m); end
        clr_err = 1'b1; drv_en = 3'b011;
        step();
        clr_err = 1'b0; drv_en = 3'b000;
        n_cmp++; if ({sat_s, sat_n} !== 3'b101) begin n_bad++; $display("FAIL clr_vs_ep: got %b want 101", {sat_s, sat_n}); end
        step();
    endtask

    task automatic test_reset_mid_episode();
        do_reset();
        drv_en = 3'b011; drv_data = {4'h0, 4'h4, 4'h3};
        step();
        step();
        n_cmp++; if (tri_c !== 1'b1) begin n_bad++; $display("FAIL mid_pre_c: got %b want 1", tri_c); end
        rst = 1'b1;
        step();
        n_cmp++; if ({tri_c, tri_s, tri_n, tri_m} !== 13'h0) begin n_bad++; $display("FAIL mid_rst_err: got %h want 0", {tri_c, tri_s, tri_n, tri_m}); end
        n_cmp++; if ({tri_q, tri_v} !== 5'h0) begin n_bad++; $display("FAIL mid_rst_bus: got %h want 0", {tri_q, tri_v}); end
        n_cmp++; if (and_q !== 4'hF) begin n_bad++; $display("FAIL mid_rst_and_q: got %h want f", and_q); end
        rst = 1'b0;
        step();
        n_cmp++; if (tri_c !== 1'b0) begin n_bad++; $display("FAIL mid_rel1_c: got %b want 0", tri_c); end
        step();
        n_cmp++; if ({tri_c, tri_n} !== {1'b1, 8'd1}) begin n_bad++; $display("FAIL mid_rel2: got %h want 101", {tri_c, tri_n}); end
        n_cmp++; if (tri_q !== 4'h0) begin n_bad++; $display("FAIL mid_keep_q: got %h want 0", tri_q); end
    endtask

    initial begin
        rst = 1'b1; drv_en = '0; drv_data = '0; clr_err = 1'b0;
        test_reset();
        test_wor();
        test_wand();
        test_tri_keeper();
        test_contention();
        test_saturate_clear();
        test_reset_mid_episode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wired_bus_resolver.md
Name: wired_bus_resolver

Overview:
- Registered N-driver bus resolver; successor to plain wor/wand net resolution.
- Parametrised in width, driver count and resolution mode: wired-OR, wired-AND, or tri-state with keeper.
- Adds filtered contention detection, an episode counter and sticky error reporting.
- Sits between multiple bus-master agents and a shared status/data bus in the test designs.

Parameters:
- WIDTH, 4, bus width in bits (>=1)
- NDRV, 3, number of drivers (>=2)
- MODE, 0, resolution mode: 0 = wired-OR, 1 = wired-AND, 2 = tri-state
- FILTER, 2, consecutive raw-conflict cycles required before `conflict` asserts (>=1)
- CNT_W, 8, width of the conflict episode counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- drv_en  in  NDRV  per-driver enable
- drv_data  in  NDRV*WIDTH  driver data; driver i occupies bits [i*WIDTH +: WIDTH]
- clr_err  in  1  clears err_sticky and err_count
- bus_q  out  WIDTH  registered resolved bus value
- bus_valid  out  1  registered; at least one driver was enabled last cycle
- conflict  out  1  registered, filtered contention flag
- err_sticky  out  1  set on any conflict episode; held until clr_err or rst
- err_count  out  CNT_W  number of conflict episodes, saturating
- err_mask  out  NDRV  drv_en snapshot taken at the start of the latest episode

Behaviour:
- Reset (rst=1 at edge):
  - bus_q = all-ones if MODE=1, else 0.
  - bus_valid, conflict, err_sticky, err_count, err_mask, run counter all = 0.
  - Reset mid-episode discards the run counter; no count increment on that edge.
- Resolution (combinational next-value, registered; latency 1 cycle from inputs to bus_q):
  - MODE 0: OR of data from enabled drivers. No driver enabled -> 0.
  - MODE 1: AND of data from enabled drivers. No driver enabled -> all-ones.
  - MODE 2, exactly one driver enabled: that driver's data.
  - MODE 2, several enabled, all data equal: that value; not a conflict.
  - MODE 2, several enabled, any data differ: bus_q holds its previous value; raw_conflict = 1.
  - MODE 2, none enabled: bus_q holds its previous value (keeper).
- bus_valid_next = |drv_en in all modes.
- raw_conflict is always 0 in MODE 0 and MODE 1, so conflict/err outputs stay at reset values.
- Filter:
  - Run counter increments while raw_conflict = 1 and saturates at FILTER; it clears to 0 on any cycle with raw_conflict = 0.
  - conflict_next = (run counter reaches FILTER this edge).
  - FILTER=1 gives conflict one cycle after raw_conflict.
- Episode:
  - An episode starts on the edge where conflict goes 0 -> 1.
  - On that edge: err_count += 1, saturating at 2^CNT_W-1; err_sticky = 1; err_mask = current drv_en.
  - No further increment while conflict remains 1.
- clr_err: err_count = 0 and err_sticky = 0 on the next edge. If an episode starts on the same edge, the episode wins: err_count = 1, err_sticky = 1. err_mask is not cleared by clr_err.
- Priority per edge: rst > episode start > clr_err.

Decomposition:
- Shared package wired_bus_pkg holds:
  - typedef enum `res_mode_e` {RES_WOR, RES_WAND, RES_TRI}
  - function `undriven_value(mode, width)`
  - localparam default widths
- One sub-module, wired_bus_conflict_filter, contains:
  - run counter
  - episode edge detection
  - saturating err_count
  - err_sticky
  - err_mask capture
- Parameters of wired_bus_conflict_filter: FILTER, CNT_W, NDRV.

Test Plan:
- MODE0, WIDTH=4, NDRV=3: en=3'b011, d0=4'b1100, d1=4'b0001 -> next cycle bus_q=4'b1101, bus_valid=1; then en=0 -> bus_q=0, bus_valid=0; conflict never asserts.
- MODE1: en=3'b101, d0=4'b1110, d2=4'b0111 -> bus_q=4'b0110; en=0 -> bus_q=4'b1111.
- MODE2, keeper and agreement:
  - en=3'b010, d1=4'hA -> bus_q=4'hA.
  - en=0 -> bus_q stays 4'hA, bus_valid=0.
  - en=3'b110, d1=d2=4'h5 -> bus_q=4'h5, no conflict.
- MODE2, FILTER=2, contention:
  - en=3'b011, d0=4'h3, d1=4'h4 held 1 cycle -> conflict stays 0, err_count=0.
  - Same held 3 cycles -> conflict=1 after the 2nd edge, err_count=1, err_sticky=1, err_mask=3'b011.
  - bus_q holds the pre-conflict value throughout.
- Counter and clear:
  - CNT_W=2, four separated episodes -> err_count saturates at 3.
  - clr_err -> err_count=0, err_sticky=0.
  - clr_err on the same edge as an episode start -> err_count=1, err_sticky=1.
- Reset mid-episode: assert rst while conflict=1 -> next edge all outputs at reset values (MODE1 bus_q=4'hF); release with contention still present -> conflict reasserts only after FILTER further cycles.
